// File: rtl/mux4_arb_pkg.sv
// mux4_arb_pkg
// Shared widths, the arbiter state encoding and a one-hot helper for the
// 4-way round-robin arbiter.
//   N_REQ  number of requesters
//   IDX_W  width of a requester index / round-robin pointer
//   CNT_W  width of the hold counter
package mux4_arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 8;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4
// Combinational round-robin picker. Searches req & ~mask in the order
// ptr, ptr+1, ptr+2, ptr+3 (mod 4) and reports the first hit.
//   req   [3:0] in   request vector
//   ptr   [1:0] in   first index to examine
//   mask  [3:0] in   requesters to exclude from the search
//   idx   [1:0] out  index of the winner (0 when nothing found)
//   found       out  a winner exists
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [N_REQ-1:0] cand;
  logic [IDX_W-1:0] pos;

  assign cand = req & ~mask;

  // Walk from the farthest offset down to offset 0 so the nearest
  // candidate in search order is the last one written and wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pos = ptr + IDX_W'(i);
      if (cand[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_arbiter.sv
// mux4_arbiter
// Round-robin arbiter producing the select for an external gate-level 4:1
// mux. One owner at a time; the owner keeps the grant until it drops its
// request or has held it for MAX_HOLD cycles while someone else waits.
//   MAX_HOLD      param  max consecutive grant cycles when others wait (1..255)
//   clk           in     system clock, rising edge
//   rst           in     asynchronous active-high reset
//   req   [3:0]   in     level-sensitive requests
//   gnt   [3:0]   out    registered grant, one-hot or zero
//   sel   [1:0]   out    registered mux select, index of the last grant
//   busy          out    registered, high while a grant is active
//
// state    | meaning
// ST_IDLE  | no grant; sel keeps the last granted index
// ST_GRANT | exactly one gnt bit high, owner = sel
module mux4_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] sel,
  output logic             busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [IDX_W-1:0] sel_nxt;
  logic             busy_nxt;

  logic [N_REQ-1:0] pick_mask;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             owner_req;
  logic             grant_new;

  // While granting, the owner is excluded so release and timeout both look
  // only at the other requesters. ptr already points one past the owner.
  assign pick_mask = (state == ST_GRANT) ? idx2onehot(sel) : '0;
  assign owner_req = req[sel];

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr),
    .mask  (pick_mask),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      sel      <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_cnt_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      busy     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    hold_cnt_nxt = hold_cnt;
    gnt_nxt      = gnt;
    sel_nxt      = sel;
    busy_nxt     = busy;
    grant_new    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pick_found) grant_new = 1'b1;
      end

      ST_GRANT: begin
        if (!owner_req) begin
          if (pick_found) begin
            grant_new = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            gnt_nxt   = '0;
            busy_nxt  = 1'b0;
          end
        end else if (hold_cnt == HOLD_LAST) begin
          // Nobody else waiting: the owner keeps gnt without a gap and
          // simply starts a fresh hold window.
          if (pick_found) grant_new = 1'b1;
          else            hold_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase

    if (grant_new) begin
      state_nxt    = ST_GRANT;
      gnt_nxt      = idx2onehot(pick_idx);
      sel_nxt      = pick_idx;
      ptr_nxt      = pick_idx + IDX_W'(1);
      hold_cnt_nxt = '0;
      busy_nxt     = 1'b1;
    end
  end

endmodule

// File: tb/tb_mux4_arbiter.sv
// tb_mux4_arbiter
// Directed bench for mux4_arbiter: three instances (MAX_HOLD = 8, 2, 3)
// share clock and reset; each directed sequence drives one of them.
module tb_mux4_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req8, req2, req3;
  logic [3:0] gnt8, gnt2, gnt3;
  logic [1:0] sel8, sel2, sel3;
  logic       busy8, busy2, busy3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux4_arbiter #(.MAX_HOLD(8)) u_h8 (
    .clk(clk), .rst(rst), .req(req8), .gnt(gnt8), .sel(sel8), .busy(busy8)
  );
  mux4_arbiter #(.MAX_HOLD(2)) u_h2 (
    .clk(clk), .rst(rst), .req(req2), .gnt(gnt2), .sel(sel2), .busy(busy2)
  );
  mux4_arbiter #(.MAX_HOLD(3)) u_h3 (
    .clk(clk), .rst(rst), .req(req3), .gnt(gnt3), .sel(sel3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rst released 1 time unit after an edge; the next tick is the first
  // arbitration edge.
  task automatic do_reset();
    rst  = 1'b1;
    req8 = '0;
    req2 = '0;
    req3 = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Fairness monitor on the MAX_HOLD = 2 instance, sampled on negedge.
  bit fair_on = 1'b0;
  int wait_cnt [4];
  int max_wait = 0;
  int oh_err   = 0;
  int sel_err  = 0;

  always @(negedge clk) begin
    if (fair_on) begin
      if ($countones(gnt2) > 1) oh_err++;
      if (busy2 != (gnt2 != 4'b0000)) sel_err++;
      if (busy2 && (gnt2 != (4'b0001 << sel2))) sel_err++;
      for (int b = 0; b < 4; b++) begin
        if (req2[b] && !gnt2[b]) wait_cnt[b]++;
        else                     wait_cnt[b] = 0;
        if (wait_cnt[b] > max_wait) max_wait = wait_cnt[b];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [3:0] seq_gnt [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010,
                              4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
  int         seq_sel [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

  initial begin
    rst  = 1'b0;
    req8 = '0;
    req2 = '0;
    req3 = '0;
    #2;

    // reset state
    do_reset();
    chk("rst_gnt8", gnt8, 4'b0000);
    chk("rst_sel8", sel8, 2'b00);
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_gnt2", gnt2, 4'b0000);
    chk("rst_gnt3", gnt3, 4'b0000);

    // single request, drop at cycle 3
    req8 = 4'b0100;
    tick();
    chk("single_c1_gnt", gnt8, 4'b0100);
    chk("single_c1_sel", sel8, 2'b10);
    chk("single_c1_busy", busy8, 1'b1);
    tick();
    chk("single_c2_gnt", gnt8, 4'b0100);
    tick();
    chk("single_c3_gnt", gnt8, 4'b0100);
    req8 = 4'b0000;
    tick();
    chk("single_c4_gnt", gnt8, 4'b0000);
    chk("single_c4_sel", sel8, 2'b10);
    chk("single_c4_busy", busy8, 1'b0);
    tick();
    tick();
    chk("single_idle_sel", sel8, 2'b10);
    chk("single_idle_gnt", gnt8, 4'b0000);

    // all request, MAX_HOLD = 2
    do_reset();
    req2 = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("allreq_gnt%0d", i), gnt2, seq_gnt[i]);
      chk($sformatf("allreq_sel%0d", i), sel2, seq_sel[i][1:0]);
    end

    // back-to-back release 0 -> 1
    do_reset();
    req8 = 4'b0011;
    tick();
    chk("b2b_own0", gnt8, 4'b0001);
    tick();
    chk("b2b_own0_hold", gnt8, 4'b0001);
    req8 = 4'b0010;
    tick();
    chk("b2b_gnt", gnt8, 4'b0010);
    chk("b2b_busy", busy8, 1'b1);
    chk("b2b_sel", sel8, 2'b01);

    // sole requester timeout, MAX_HOLD = 3
    do_reset();
    req3 = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("sole_gnt%0d", i), gnt3, 4'b1000);
      chk($sformatf("sole_sel%0d", i), sel3, 2'b11);
    end

    // non-owner changes ignored, timeout hand-off at MAX_HOLD = 8
    do_reset();
    req8 = 4'b0001;
    tick();
    chk("nonown_c1", gnt8, 4'b0001);
    req8 = 4'b1111;
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk($sformatf("nonown_c%0d", c), gnt8, 4'b0001);
    end
    req8 = 4'b1101;
    for (int c = 5; c <= 8; c++) begin
      tick();
      chk($sformatf("nonown_c%0d", c), gnt8, 4'b0001);
    end
    tick();
    chk("timeout_c9_gnt", gnt8, 4'b0100);
    chk("timeout_c9_sel", sel8, 2'b10);

    // async reset between edges while granting
    req8 = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_gnt", gnt8, 4'b0000);
    chk("async_rst_sel", sel8, 2'b00);
    chk("async_rst_busy", busy8, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_first_gnt", gnt8, 4'b0001);
    chk("post_rst_first_sel", sel8, 2'b00);

    // random fairness run on MAX_HOLD = 2
    do_reset();
    for (int b = 0; b < 4; b++) wait_cnt[b] = 0;
    fair_on = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(5) == 0) req2[b] = ~req2[b];
      end
      tick();
    end
    fair_on = 1'b0;
    chk("fair_onehot_errs", oh_err, 0);
    chk("fair_sel_errs", sel_err, 0);
    chk("fair_wait_bound", (max_wait <= 3 * 2 + 3), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
